// File: rtl/hazard_forward_unit.sv
// ---------------------------------------------------------------------------
// hazard_forward_unit
//
// Purpose:
//   Hazard and forwarding logic for the 16-bit, 5-stage CPU. The unit keeps
//   a compact per-stage record of what each in-flight instruction reads and
//   writes, for the ID/EX, EX/MEM and MEM/WB stages. It compares that state
//   against the ID/EX instruction to produce forwarding selects, and against
//   the IF/ID instruction to produce the load-use stall.
//
// Ports:
//   clk            pipeline clock
//   rst            synchronous, active-high reset (clears all tracking state)
//   instructions1  instruction currently in IF/ID (entering decode)
//   fromCompare    branch taken this cycle; IF/ID contents are squashed
//   needM4         ID/EX op1 takes the EX/MEM result
//   needM5         ID/EX op1 takes the MEM/WB result
//   needM2         ID/EX op2 takes the EX/MEM result
//   needM2W        ID/EX op2 takes the MEM/WB result
//   bubble2        load-use stall: hold IF/ID, inject a bubble into ID/EX
//   halted         sticky; set once a halt instruction has reached ID/EX
//
// Instruction fields: opcode[15:12], op1[11:8], op2[7:4], func/imm[3:0].
//
// The unit has no valid/ready handshakes. Every input is sampled on each
// rising clock edge, and every output is a level that is valid for the
// current cycle. No request/acknowledge pairing is implied.
// ---------------------------------------------------------------------------
module hazard_forward_unit #(
    parameter int NREG = 16,
    parameter int R_HI = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] instructions1,
    input  logic        fromCompare,
    output logic        needM4,
    output logic        needM5,
    output logic        needM2,
    output logic        needM2W,
    output logic        bubble2,
    output logic        halted
);

    localparam int RW = $clog2(NREG);
    localparam logic [RW-1:0] RHI = RW'(R_HI);

    localparam logic [3:0] OP_ALU   = 4'b0000;
    localparam logic [3:0] OP_BEQ   = 4'b0100;
    localparam logic [3:0] OP_BNE   = 4'b0101;
    localparam logic [3:0] OP_BLT   = 4'b0110;
    localparam logic [3:0] OP_LOAD  = 4'b1000;
    localparam logic [3:0] OP_STORE = 4'b1011;
    localparam logic [3:0] OP_HALT  = 4'b1111;

    // What one in-flight instruction reads and writes.
    typedef struct packed {
        logic          valid;
        logic          wr_op1;
        logic          wr_hi;
        logic [RW-1:0] dest;
        logic          is_load;
        logic          is_halt;
        logic          rd_op1;
        logic          rd_op2;
        logic [RW-1:0] src1;
        logic [RW-1:0] src2;
    } stage_t;

    // Turns a raw instruction into its read/write record.
    function automatic stage_t decode(input logic [15:0] ins);
        stage_t d;
        d       = '0;
        d.valid = 1'b1;
        d.dest  = RW'(ins[11:8]);
        d.src1  = RW'(ins[11:8]);
        d.src2  = RW'(ins[7:4]);
        case (ins[15:12])
            OP_ALU: begin
                case (ins[3:0])
                    4'hF, 4'hE, 4'hD, 4'hC: begin
                        d.rd_op1 = 1'b1;
                        d.rd_op2 = 1'b1;
                        d.wr_op1 = 1'b1;
                    end
                    // mul/div also write the high half / remainder register
                    4'h1, 4'h2: begin
                        d.rd_op1 = 1'b1;
                        d.rd_op2 = 1'b1;
                        d.wr_op1 = 1'b1;
                        d.wr_hi  = 1'b1;
                    end
                    // shifts use op2 as an amount field, not a register
                    4'hA, 4'hB, 4'h8, 4'h9: begin
                        d.rd_op1 = 1'b1;
                        d.wr_op1 = 1'b1;
                    end
                    default: ;
                endcase
            end
            OP_LOAD: begin
                d.rd_op2  = 1'b1;
                d.wr_op1  = 1'b1;
                d.is_load = 1'b1;
            end
            OP_STORE, OP_BEQ, OP_BNE, OP_BLT: begin
                d.rd_op1 = 1'b1;
                d.rd_op2 = 1'b1;
            end
            OP_HALT: d.is_halt = 1'b1;
            default: ;
        endcase
        return d;
    endfunction

    // True when stage st produces a value for register s.
    function automatic logic hits(input stage_t st, input logic [RW-1:0] s);
        return st.valid && ((st.wr_op1 && (st.dest == s)) ||
                            (st.wr_hi && (s == RHI)));
    endfunction

    stage_t idex;
    stage_t exmem;
    stage_t memwb;
    stage_t dec_if;

    logic op1_ex;
    logic op1_wb;
    logic op2_ex;
    logic op2_wb;
    logic use_dep;

    always_comb begin
        dec_if  = decode(instructions1);

        op1_ex  = idex.valid && idex.rd_op1 && hits(exmem, idex.src1);
        op1_wb  = idex.valid && idex.rd_op1 && hits(memwb, idex.src1);
        op2_ex  = idex.valid && idex.rd_op2 && hits(exmem, idex.src2);
        op2_wb  = idex.valid && idex.rd_op2 && hits(memwb, idex.src2);

        // Does the decoding instruction read the register the load in ID/EX
        // is about to write? A load never writes R_HI, so only dest matters.
        use_dep = (dec_if.rd_op1 && (dec_if.src1 == idex.dest)) ||
                  (dec_if.rd_op2 && (dec_if.src2 == idex.dest));

        // EX/MEM holds the younger result, so it wins over MEM/WB.
        needM4  = !halted && op1_ex;
        needM5  = !halted && !op1_ex && op1_wb;
        needM2  = !halted && op2_ex;
        needM2W = !halted && !op2_ex && op2_wb;

        // A taken branch discards IF/ID anyway, so no stall is needed then.
        bubble2 = !halted && !fromCompare && idex.valid && idex.is_load &&
                  idex.wr_op1 && use_dep;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            idex   <= '0;
            exmem  <= '0;
            memwb  <= '0;
            halted <= 1'b0;
        end else if (!halted) begin
            // The halt advances with this edge like any other instruction;
            // from the next cycle on the whole record freezes.
            if (idex.valid && idex.is_halt) begin
                halted <= 1'b1;
            end
            memwb <= exmem;
            exmem <= idex;
            idex  <= (bubble2 || fromCompare) ? '0 : dec_if;
        end
    end

endmodule

// File: tb/tb_hazard_forward_unit.sv
// ---------------------------------------------------------------------------
// tb_hazard_forward_unit
//
// Directed bench for hazard_forward_unit. Each step drives instructions1,
// fromCompare and rst shortly after a rising edge, checks the combinational
// outputs against a hand-derived vector, then advances one clock.
// Output vector order: {needM4, needM5, needM2, needM2W, bubble2, halted}.
// ---------------------------------------------------------------------------
module tb_hazard_forward_unit;

    logic        clk;
    logic        rst;
    logic [15:0] instructions1;
    logic        fromCompare;
    logic        needM4;
    logic        needM5;
    logic        needM2;
    logic        needM2W;
    logic        bubble2;
    logic        halted;

    logic [5:0]  outs;
    int          compared;
    int          mismatched;

    hazard_forward_unit #(.NREG(16), .R_HI(0)) dut (
        .clk           (clk),
        .rst           (rst),
        .instructions1 (instructions1),
        .fromCompare   (fromCompare),
        .needM4        (needM4),
        .needM5        (needM5),
        .needM2        (needM2),
        .needM2W       (needM2W),
        .bubble2       (bubble2),
        .halted        (halted)
    );

    // clock / reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign outs = {needM4, needM5, needM2, needM2W, bubble2, halted};

    // driver tasks
    task automatic drive(input logic [15:0] ins, input logic f, input logic r);
        instructions1 = ins;
        fromCompare   = f;
        rst           = r;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // comparison point
    task automatic check(input string tag, input logic [5:0] exp);
        compared++;
        assert (outs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed m4m5m2m2w_b_h=%b required %b", tag, outs, exp);
        end
    endtask

    initial begin
        compared      = 0;
        mismatched    = 0;
        rst           = 1'b1;
        instructions1 = 16'h0000;
        fromCompare   = 1'b0;
        tick();
        tick();

        // Test 1: add R1,R2 then sub R3,R1 / sub R1,R3
        drive(16'h012F, 0, 0); check("reset_outputs_zero", 6'b000000); tick();
        drive(16'h031E, 0, 0); check("add_in_idex_no_deps", 6'b000000); tick();
        drive(16'h012F, 0, 0); check("sub31_op2_from_exmem", 6'b001000); tick();
        drive(16'h013E, 0, 0); check("add12_op1_from_memwb", 6'b010000); tick();
        drive(16'hC000, 0, 0); check("sub13_op1_ex_op2_wb", 6'b100100); tick();

        // Test 2: add, jump, sub -> op2 from MEM/WB
        drive(16'h012F, 0, 0); check("jump_reads_nothing", 6'b000000); tick();
        drive(16'hC000, 0, 0); check("add12_after_sub13_wb", 6'b010000); tick();
        drive(16'h031E, 0, 0); check("jump_in_idex_again", 6'b000000); tick();

        // Test 3: load R4 then add R6,R4
        drive(16'h8450, 0, 0); check("sub31_op2_wb_only", 6'b000100); tick();
        drive(16'h064F, 0, 0); check("load_use_stall", 6'b000010); tick();
        drive(16'h064F, 0, 0); check("stall_one_cycle_only", 6'b000000); tick();
        drive(16'h0231, 0, 0); check("add64_op2_from_load_wb", 6'b000100); tick();

        // Test 4: mul writes R_HI (R0); shifts read op1 only
        drive(16'h010F, 0, 0); check("mul_no_deps", 6'b000000); tick();
        drive(16'h0231, 0, 0); check("add10_op2_via_rhi_ex", 6'b001000); tick();
        drive(16'h000A, 0, 0); check("mul_op1_from_mul_wb", 6'b010000); tick();
        drive(16'h0F0A, 0, 0); check("shift0_op1_via_rhi_ex", 6'b100000); tick();
        drive(16'h012F, 0, 0); check("shiftF_ignores_op2", 6'b000000); tick();

        // priority, store, branch, other ALU func
        drive(16'h013F, 0, 0); check("add12_no_writer", 6'b000000); tick();
        drive(16'h041E, 0, 0); check("add13_op1_from_exmem", 6'b100000); tick();
        drive(16'hB120, 0, 0); check("exmem_beats_memwb", 6'b001000); tick();
        drive(16'h4410, 0, 0); check("store_op1_from_memwb", 6'b010000); tick();
        drive(16'h0103, 0, 0); check("branch_op1_from_memwb", 6'b010000); tick();

        // Test 5: flush overrides the load-use stall
        drive(16'h8450, 0, 0); check("other_alu_reads_none", 6'b000000); tick();
        drive(16'h064F, 1, 0); check("flush_suppresses_stall", 6'b000000); tick();
        drive(16'h064F, 0, 0); check("flushed_idex_invalid", 6'b000000); tick();
        drive(16'h8450, 0, 0); check("add64_op2_wb_after_flush", 6'b000100); tick();

        // reset mid-stream drops a pending stall
        drive(16'h064F, 0, 1); check("stall_before_reset", 6'b000010); tick();
        drive(16'h064F, 0, 0); check("stall_dropped_by_reset", 6'b000000); tick();

        // Test 6: halt
        drive(16'hF000, 0, 0); check("add64_after_reset", 6'b000000); tick();
        drive(16'h8460, 0, 0); check("halt_in_idex_not_yet", 6'b000000); tick();
        drive(16'h064F, 0, 0); check("halted_masks_outputs", 6'b000001); tick();
        drive(16'h0F4F, 0, 0); check("halted_sticky", 6'b000001); tick();
        drive(16'h064F, 0, 1); check("halted_before_rst", 6'b000001); tick();
        drive(16'h012F, 0, 0); check("rst_clears_halted", 6'b000000); tick();
        drive(16'h031E, 0, 0); check("restart_add_in_idex", 6'b000000); tick();
        drive(16'h0000, 0, 0); check("restart_forwarding", 6'b001000); tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
